// File: rtl/csr_counter_unit_pkg.sv
// Shared types, CSR address map and read-modify-write helpers for csr_counter_unit.
package csr_counter_unit_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_t;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

  function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old | wdata;
      CSR_OP_CLEAR: return old & ~wdata;
      default:      return old;
    endcase
  endfunction

  // SET/CLEAR with an all-zero mask is a pure read and never modifies state.
  function automatic logic csr_is_write(input csr_op_t op, input logic [31:0] wdata);
    return (op == CSR_OP_WRITE) ||
           (((op == CSR_OP_SET) || (op == CSR_OP_CLEAR)) && (wdata != 32'd0));
  endfunction

endpackage

// File: rtl/csr_counter_unit_perf_counter.sv
// Free-running counter with independently writable low/high halves; a write
// in the same cycle as an increment discards the increment.
module perf_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[WIDTH-1:32] <= wdata[WIDTH-33:0];
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/csr_counter_unit.sv
// Cycle/instret/HPM counter bank with CSR read/write/set/clear and legality checks.
// Build option: define CSR_HPM_EN to implement mhpmcounter/mhpmevent registers.
module csr_counter_unit
  import csr_counter_unit_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_HPM       = 4,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_enable,
  input  logic                  instret_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  csr_valid,
  input  logic [1:0]            csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_illegal
);

`ifdef CSR_HPM_EN
  localparam int HPM_N = NUM_HPM;
`else
  localparam int HPM_N = 0;
`endif
  localparam int NCNT = 2 + HPM_N;
  localparam int EA   = (HPM_N > 0) ? HPM_N : 1;
  localparam int EW   = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << HPM_N) - 32'd1) << 3);

  csr_op_t op;
  assign op = csr_op_t'(csr_op);

  logic [COUNTER_WIDTH-1:0] cnt [NCNT];
  logic [EW-1:0]            evt [EA];
  logic [31:0]              inhibit;
  logic [EA-1:0]            hpm_inc;
  logic [NCNT-1:0]          inc;
  logic [NCNT-1:0]          wr_lo;
  logic [NCNT-1:0]          wr_hi;

  logic        access, commit, illegal, eff_write;
  logic        is_cnt, is_evt, is_inh, shadow, hi;
  int          cidx, eidx;
  logic [11:0] base, eoff;
  logic [4:0]  num;
  logic [63:0] cnt_ext;
  logic [31:0] old, wval;

  // Counter addresses fold B/C ranges and the high-half bit onto a 5-bit index.
  always_comb begin
    base   = csr_addr & 12'hF7F;
    hi     = csr_addr[7];
    num    = csr_addr[4:0];
    eoff   = csr_addr - CSR_MHPMEVENT3;
    is_cnt = 1'b0;
    is_evt = 1'b0;
    is_inh = 1'b0;
    shadow = 1'b0;
    cidx   = 0;
    eidx   = 0;
    if (((base & 12'hFE0) == CSR_MCYCLE) || ((base & 12'hFE0) == CSR_CYCLE)) begin
      shadow = ((base & 12'hFE0) == CSR_CYCLE);
      if ((num == CSR_MCYCLE[4:0]) || ((num == CSR_TIME[4:0]) && shadow)) begin
        is_cnt = 1'b1;
        cidx   = 0;
      end else if (num == CSR_MINSTRET[4:0]) begin
        is_cnt = 1'b1;
        cidx   = 1;
      end else if ((int'(num) >= 3) && (int'(num) < 3 + HPM_N)) begin
        is_cnt = 1'b1;
        cidx   = int'(num) - 1;
      end
    end else if (csr_addr == CSR_MCOUNTINHIBIT) begin
      is_inh = 1'b1;
    end else if ((csr_addr >= CSR_MHPMEVENT3) && (int'(eoff) < HPM_N)) begin
      is_evt = 1'b1;
      eidx   = int'(eoff);
    end

    cnt_ext = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (cidx == k) cnt_ext = 64'(cnt[k]);
    end

    old = '0;
    if (is_cnt) begin
      old = hi ? cnt_ext[63:32] : cnt_ext[31:0];
    end else if (is_evt) begin
      for (int k = 0; k < EA; k++) begin
        if (eidx == k) old = 32'(evt[k]);
      end
    end else if (is_inh) begin
      old = inhibit;
    end

    eff_write = csr_is_write(op, csr_wdata);
    illegal   = (op == CSR_OP_NONE) || !(is_cnt || is_evt || is_inh) || (shadow && eff_write);
    access    = csr_valid && pipe_enable;
    commit    = access && !illegal && eff_write;
    wval      = csr_apply(op, old, csr_wdata);
  end

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (commit && is_cnt && (cidx == k)) begin
        wr_lo[k] = !hi;
        wr_hi[k] = hi;
      end
    end
  end

  always_comb begin
    hpm_inc = '0;
    for (int k = 0; k < EA; k++) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if ((int'(evt[k]) == e + 1) && event_i[e] && pipe_enable && !inhibit[3+k])
          hpm_inc[k] = 1'b1;
      end
    end
  end

  logic unused_hpm;
  assign unused_hpm = ^hpm_inc;

  assign inc[0] = !inhibit[0];
  assign inc[1] = instret_i && pipe_enable && !inhibit[2];

  for (genvar g = 0; g < HPM_N; g++) begin : g_hpm_inc
    assign inc[2+g] = hpm_inc[g];
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    perf_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[g]),
      .wr_lo (wr_lo[g]),
      .wr_hi (wr_hi[g]),
      .wdata (wval),
      .value (cnt[g])
    );
  end

  // Event selectors are WARL: out-of-range selections are stored as 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      inhibit     <= '0;
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      for (int k = 0; k < EA; k++) evt[k] <= '0;
    end else if (access) begin
      csr_illegal <= illegal;
      csr_rdata   <= illegal ? 32'd0 : old;
      if (commit && is_inh) inhibit <= wval & INH_MASK;
      for (int k = 0; k < EA; k++) begin
        if (commit && is_evt && (eidx == k))
          evt[k] <= (wval > 32'(NUM_EVENTS)) ? '0 : wval[EW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Randomized and directed bench for csr_counter_unit at widths 64 and 40 against a behavioural model.
module tb_csr_counter_unit;
  import csr_counter_unit_pkg::*;

`ifdef CSR_HPM_EN
  localparam int NH = 4;
`else
  localparam int NH = 0;
`endif
  localparam int NEV = 8;

  logic        clk = 1'b0;
  logic        reset, pipe_enable, instret_i, csr_valid;
  logic [7:0]  event_i;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] rd64, rd40;
  logic        ill64, ill40;

  int n_tests = 0;
  int n_fail  = 0;

  csr_counter_unit #(.COUNTER_WIDTH(64), .NUM_HPM(4), .NUM_EVENTS(NEV)) u_w64 (
    .clk(clk), .reset(reset), .pipe_enable(pipe_enable), .instret_i(instret_i),
    .event_i(event_i), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(rd64), .csr_illegal(ill64));

  csr_counter_unit #(.COUNTER_WIDTH(40), .NUM_HPM(4), .NUM_EVENTS(NEV)) u_w40 (
    .clk(clk), .reset(reset), .pipe_enable(pipe_enable), .instret_i(instret_i),
    .event_i(event_i), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(rd40), .csr_illegal(ill40));

  always #5 clk = ~clk;

  // Reference state per instance (0: 64-bit, 1: 40-bit), values kept as plain integers.
  logic [63:0] m_cyc [2];
  logic [63:0] m_ir  [2];
  logic [63:0] m_hpm [2][4];
  logic [31:0] m_evt [2][4];
  logic [31:0] m_inh [2];
  logic [31:0] e_rd  [2];
  logic        e_ill [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int i = 0; i < NH; i++) m[3+i] = 1'b1;
    return m;
  endfunction

  // kind: -1 unimplemented, 0 counter (0 cycle, 1 instret, 2+i hpm i), 1 event select, 2 inhibit
  function automatic void mdec(input logic [11:0] a, output int kind, output int idx,
                               output bit hi, output bit sh);
    int n;
    kind = -1; idx = 0; hi = a[7]; sh = 1'b0; n = int'(a[4:0]);
    if (a == 12'h320) kind = 2;
    else if ((a >= 12'h323) && (int'(a) - 'h323 < NH)) begin
      kind = 1; idx = int'(a) - 'h323;
    end else if (((a[11:8] == 4'hB) || (a[11:8] == 4'hC)) && (a[6:5] == 2'b00)) begin
      sh = (a[11:8] == 4'hC);
      if ((n == 0) || ((n == 1) && sh)) begin kind = 0; idx = 0; end
      else if (n == 2) begin kind = 0; idx = 1; end
      else if ((n >= 3) && (n < 3 + NH)) begin kind = 0; idx = n - 1; end
    end
  endfunction

  task automatic model_step();
    logic [63:0] ncyc, nir, full, msk;
    logic [63:0] nh [4];
    logic [31:0] nev [4];
    logic [31:0] ninh, old, nv;
    int kind, idx, sel;
    bit hi, sh, ill, eff;
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        m_cyc[u] = 0; m_ir[u] = 0; m_inh[u] = 0; e_rd[u] = 0; e_ill[u] = 0;
        for (int i = 0; i < 4; i++) begin m_hpm[u][i] = 0; m_evt[u][i] = 0; end
      end
      return;
    end
    for (int u = 0; u < 2; u++) begin
      msk  = (u == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_00FF_FFFF_FFFF;
      ncyc = m_inh[u][0] ? m_cyc[u] : ((m_cyc[u] + 64'd1) & msk);
      nir  = (instret_i && pipe_enable && !m_inh[u][2]) ? ((m_ir[u] + 64'd1) & msk) : m_ir[u];
      for (int i = 0; i < 4; i++) begin
        nh[i]  = m_hpm[u][i];
        nev[i] = m_evt[u][i];
        sel    = int'(m_evt[u][i]);
        if ((i < NH) && pipe_enable && !m_inh[u][3+i] && (sel >= 1) && (sel <= NEV) && event_i[sel-1])
          nh[i] = (m_hpm[u][i] + 64'd1) & msk;
      end
      ninh = m_inh[u];
      if (csr_valid && pipe_enable) begin
        mdec(csr_addr, kind, idx, hi, sh);
        eff = (csr_op == 2'd1) || (csr_wdata != 32'd0);
        ill = (csr_op == 2'd0) || (kind < 0) || (sh && eff);
        if (ill) begin
          e_rd[u] = 0; e_ill[u] = 1'b1;
        end else begin
          full = 0;
          if (kind == 0) begin
            if (idx == 0) full = m_cyc[u];
            else if (idx == 1) full = m_ir[u];
            else full = m_hpm[u][idx-2];
          end
          if (kind == 0) old = hi ? full[63:32] : full[31:0];
          else if (kind == 1) old = m_evt[u][idx];
          else old = m_inh[u];
          e_rd[u] = old; e_ill[u] = 1'b0;
          if (eff) begin
            case (csr_op)
              2'd1:    nv = csr_wdata;
              2'd2:    nv = old | csr_wdata;
              default: nv = old & ~csr_wdata;
            endcase
            if (kind == 0) begin
              full = hi ? {nv, full[31:0]} : {full[63:32], nv};
              full = full & msk;
              if (idx == 0) ncyc = full;
              else if (idx == 1) nir = full;
              else nh[idx-2] = full;
            end else if (kind == 1) begin
              nev[idx] = (nv > NEV) ? 32'd0 : nv;
            end else begin
              ninh = nv & inh_mask();
            end
          end
        end
      end
      m_cyc[u] = ncyc; m_ir[u] = nir; m_inh[u] = ninh;
      for (int i = 0; i < 4; i++) begin m_hpm[u][i] = nh[i]; m_evt[u][i] = nev[i]; end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("rdata_w64", rd64, e_rd[0]);
    check("illegal_w64", ill64, e_ill[0]);
    check("rdata_w40", rd40, e_rd[1]);
    check("illegal_w40", ill40, e_ill[1]);
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd;
    cyc();
    csr_valid = 1'b0; csr_op = 2'd0;
  endtask

  task automatic rd(input logic [11:0] a);
    acc(2'd2, a, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic [11:0] addrs [24] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06,
                              12'hB07, 12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                              12'hC03, 12'hC86, 12'hB01, 12'h320, 12'h323, 12'h324, 12'h326,
                              12'h327, 12'h7FF, 12'hC1F};

  initial begin
    reset = 1'b1; pipe_enable = 1'b1; instret_i = 1'b0; event_i = '0;
    csr_valid = 1'b0; csr_op = 2'd0; csr_addr = '0; csr_wdata = '0;

    cyc();
    check("reset_rdata", rd64, 0);
    check("reset_illegal", ill64, 0);
    reset = 1'b0;

    repeat (10) cyc();
    rd(12'hC00); check("cycle_after_10", rd64, 10);
    rd(12'hC80); check("cycleh_after_10", rd64, 0);

    acc(2'd1, 12'hB00, 32'hFFFF_FFFF);
    acc(2'd1, 12'hB80, 32'hFFFF_FFFF);
    rd(12'hB80);
    check("mcycleh_full_w64", rd64, 32'hFFFF_FFFF);
    check("mcycleh_full_w40", rd40, 32'h0000_00FF);
    rd(12'hB80);
    check("mcycleh_wrap_w64", rd64, 0);
    check("mcycleh_wrap_w40", rd40, 0);

    do_reset();
    acc(2'd1, 12'h323, 32'd2);
    event_i = 8'h02; repeat (5) cyc();
    event_i = 8'h01; repeat (3) cyc();
    pipe_enable = 1'b0; event_i = 8'h02; repeat (2) cyc();
    pipe_enable = 1'b1; event_i = 8'h00;
    rd(12'hB03);
    check("hpm3_count", rd64, (NH > 0) ? 5 : 0);
    check("hpm3_illegal", ill64, (NH > 0) ? 0 : 1);
    acc(2'd1, 12'h323, 32'd200);
    rd(12'h323);
    check("event_warl_over", rd64, 0);
    acc(2'd1, 12'h323, 32'd8);
    rd(12'h323);
    check("event_warl_max", rd64, (NH > 0) ? 8 : 0);

    do_reset();
    acc(2'd2, 12'h320, 32'd5);
    instret_i = 1'b1;
    repeat (20) cyc();
    rd(12'hB00); check("inhibit_cycle_frozen", rd64, 1);
    rd(12'hB02); check("inhibit_instret_frozen", rd64, 0);
    acc(2'd3, 12'h320, 32'd1);
    rd(12'hB00); check("cycle_resume_first", rd64, 1);
    repeat (3) cyc();
    rd(12'hB00); check("cycle_resumed", rd64, 5);
    rd(12'hB02); check("instret_still_frozen", rd64, 0);
    rd(12'h320); check("inhibit_value", rd64, 4);
    instret_i = 1'b0;

    acc(2'd1, 12'hC00, 32'd1234);
    check("shadow_write_illegal", ill64, 1);
    check("shadow_write_rdata", rd64, 0);
    rd(12'hC00);
    check("shadow_read_legal", ill64, 0);
    check("shadow_read_value", rd64, 9);
    acc(2'd3, 12'hC00, 32'd1); check("shadow_clear_illegal", ill64, 1);
    rd(12'h7FF);
    check("unimpl_illegal", ill64, 1);
    check("unimpl_rdata", rd64, 0);
    acc(2'd0, 12'hB00, 32'd0); check("op_none_illegal", ill64, 1);
    rd(12'hB01); check("b01_illegal", ill64, 1);
    rd(12'hC01); check("time_alias", rd64, 14);

    do_reset();
    instret_i = 1'b1;
    acc(2'd1, 12'hB02, 32'd100);
    instret_i = 1'b0;
    rd(12'hB02); check("write_beats_inc", rd64, 100);

    pipe_enable = 1'b0;
    acc(2'd1, 12'hB02, 32'd55);
    pipe_enable = 1'b1;
    rd(12'hB02); check("no_access_when_stalled", rd64, 100);

    instret_i = 1'b1;
    repeat (5) cyc();
    do_reset();
    instret_i = 1'b0;
    rd(12'hB00); check("reset_mid_cycle", rd64, 0);
    rd(12'hB02); check("reset_mid_instret", rd64, 0);

    repeat (3000) begin
      reset       = ($urandom_range(0, 299) == 0);
      pipe_enable = ($urandom_range(0, 3) != 0);
      instret_i   = 1'($urandom);
      event_i     = 8'($urandom);
      csr_valid   = 1'($urandom);
      csr_op      = 2'($urandom);
      csr_addr    = addrs[$urandom_range(0, 23)];
      case ($urandom_range(0, 3))
        0:       csr_wdata = 32'd0;
        1:       csr_wdata = $urandom_range(0, 12);
        2:       csr_wdata = 32'hFFFF_FFFF;
        default: csr_wdata = $urandom;
      endcase
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Parametrised replacement for the hard-wired cycle/time/instret counters and CSR read mux in the core's memory stage.
- Holds cycle, instret and NUM_HPM configurable hardware-performance counters, each with a per-counter event selector and an mcountinhibit mask.
- Implements CSR read/write/set/clear with legality checking. Sits beside the memory stage; retire pulses come from writeback, event pulses from the pipeline.

Parameters:
- COUNTER_WIDTH, 64, counter width in bits; legal range 33..64. Bits at or above COUNTER_WIDTH read as 0.
- NUM_HPM, 4, number of mhpmcounter/mhpmevent pairs; legal range 0..29, numbered 3..3+NUM_HPM-1.
- NUM_EVENTS, 8, width of the event_i bus; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pipe_enable  in  1  pipeline advance; gates retire counting and CSR access.
- instret_i  in  1  writeback retired-instruction pulse.
- event_i  in  NUM_EVENTS  one-cycle event pulses.
- csr_valid  in  1  CSR access request in the memory stage.
- csr_op  in  2  csr_op_t: NONE=0, WRITE=1, SET=2, CLEAR=3.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  write value or mask.
- csr_rdata  out  32  registered old value of the addressed CSR.
- csr_illegal  out  1  registered illegal-access flag.

Behaviour:
- Reset: all counters, mhpmevent registers, mcountinhibit, csr_rdata and csr_illegal are 0. Reset overrides everything in the same cycle.
- cycle/mcycle: +1 every clock unless mcountinhibit[0]. Independent of pipe_enable.
- time aliases cycle.
- instret/minstret: +1 when instret_i && pipe_enable && !mcountinhibit[2].
- mhpmcounter(3+i): +1 when pipe_enable && !mcountinhibit[3+i] && sel != 0 && sel <= NUM_EVENTS && event_i[sel-1], where sel = mhpmevent(3+i).
- mhpmevent registers are WARL: a written value above NUM_EVENTS is stored as 0. Stored width is clog2(NUM_EVENTS+1); reads are zero-extended.
- All counters wrap from 2^COUNTER_WIDTH-1 to 0 silently.
- Address map:
  - Machine counters: mcycle B00/B80, minstret B02/B82, mhpmcounterN B0N/B8N.
  - mhpmeventN: 32N.
  - mcountinhibit: 320. Writable bits are 0, 2 and 3..3+NUM_HPM-1; all other bits read 0.
  - User read-only shadows: cycle C00/C80, time C01/C81, instret C02/C82, hpmcounterN C0N/C8N.
- An access occurs when csr_valid && pipe_enable. Latency is 1: csr_rdata and csr_illegal update on the following edge. Outputs hold their value when there is no access.
- Write data per op: WRITE stores wdata; SET stores old|wdata; CLEAR stores old&~wdata. The operation is an effective write unless it is SET or CLEAR with wdata==0 (read-only access).
- A write to the low address replaces bits 31:0; a write to the high address replaces bits COUNTER_WIDTH-1:32. No carry into the other half.
- A write wins over an increment of the same register in the same cycle; that increment is lost.
- Illegal accesses (csr_illegal=1, csr_rdata=0, no state change):
  - an unimplemented address;
  - an effective write to a C-range shadow;
  - csr_op==NONE with csr_valid.
- A read returns the value before any same-cycle write or increment.

Optional Feature:
- Macro: CSR_HPM_EN.
- Defined: mhpmcounter/mhpmevent and their shadows implemented as above.
- Undefined: NUM_HPM is ignored and those addresses are illegal. mcountinhibit bits 3+ read 0 and ignore writes. cycle, time and instret are unaffected.

Decomposition:
- In types.sv:
  - csr_op_t enum;
  - csr address localparams (CSR_MCYCLE, CSR_MINSTRET, CSR_MHPMCOUNTER3, CSR_MHPMEVENT3, CSR_MCOUNTINHIBIT, CSR_CYCLE, CSR_TIME, CSR_INSTRET and their H variants).
- Sub-module perf_counter (parameter WIDTH): ports inc, wr_lo, wr_hi, wdata, value. Implements the write-over-increment rule and wrap. Instantiated 2+NUM_HPM times.

Test Plan:
- Reset, run 10 clocks, then read C00 -> csr_rdata=10 one cycle later; C80 -> 0.
- WRITE B00 with FFFFFFFF, then WRITE B80 with FFFFFFFF (COUNTER_WIDTH=64); 2 clocks later read B80 -> 0 (wrapped). With COUNTER_WIDTH=40, read B80 after writing FFFFFFFF -> 000000FF.
- WRITE 323 with 2; pulse event_i[1] 5 times and event_i[0] 3 times with pipe_enable=1, plus 2 event_i[1] pulses with pipe_enable=0 -> read B03 = 5. WRITE 323 with 200 (NUM_EVENTS=8), then read 323 -> 0.
- SET 320 with 5, hold 20 clocks -> cycle and instret unchanged. CLEAR 320 with 1 -> cycle resumes and instret stays frozen.
- WRITE C00 -> csr_illegal=1 and cycle not modified. SET C00 with wdata=0 -> csr_illegal=0 and old value returned. Read 7FF -> csr_illegal=1, csr_rdata=0.
- In the same cycle, WRITE B02 with 100 and assert instret_i -> minstret=100, not 101. Assert reset mid-count -> all counters 0 on the next edge.
